// File: rtl/frontend_command_definition_pkg.sv
// Shared definitions for the frontend command path: scheduler states, address
// geometry and the {valid,addr} write-queue entry layout.
package frontend_command_definition_pkg;

    localparam int ROW_ADDR_BITS  = 14;
    localparam int COL_ADDR_BITS  = 10;
    localparam int BANK_ADDR_BITS = 3;
    localparam int DEF_ADDR_W     = ROW_ADDR_BITS + COL_ADDR_BITS + BANK_ADDR_BITS;
    localparam int WIN_SIZE       = 8;

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_R2W   = 2'd1,
        S_WRITE = 2'd2,
        S_W2R   = 2'd3
    } sched_state_t;

    typedef logic [DEF_ADDR_W-1:0] def_addr_t;

    typedef struct packed {
        logic      valid;
        def_addr_t addr;
    } wq_entry_t;

endpackage

// File: rtl/raw_hazard_cmp.sv
// Combinational WIN-way compare of a read address against the visible
// write-queue window; hit when any valid entry carries the same address.
module raw_hazard_cmp
    import frontend_command_definition_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WIN    = WIN_SIZE
) (
    input  logic [WIN*(ADDR_W+1)-1:0] i_window,
    input  logic [ADDR_W-1:0]         i_addr,
    output logic                      o_hit
);

    localparam int EW = ADDR_W + 1;

    function automatic logic entry_match(input logic [ADDR_W:0] entry, input logic [ADDR_W-1:0] addr);
        return entry[ADDR_W] && (entry[ADDR_W-1:0] == addr);
    endfunction

    // OR-reduce the per-entry matches across the window
    always_comb begin
        o_hit = 1'b0;
        for (int k = 0; k < WIN; k++) begin
            o_hit = o_hit | entry_match(i_window[k*EW +: EW], i_addr);
        end
    end

endmodule

// File: rtl/write_drain_scheduler.sv
// Read/write mode scheduler: serves reads by default, drains the write FIFO in
// watermark-driven bursts with turnaround gaps, and stalls reads that hit a pending write.
module write_drain_scheduler
    import frontend_command_definition_pkg::*;
#(
    parameter int  ADDR_W       = DEF_ADDR_W,
    parameter int  WQ_DEPTH     = 16,
    parameter int  WIN          = WIN_SIZE,
    parameter int  HI_WM        = 12,
    parameter int  LO_WM        = 4,
    parameter int  WR_BURST_MAX = 8,
    parameter int  TURN_CYC     = 2,
    localparam int CW           = $clog2(WQ_DEPTH) + 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_rd_valid,
    input  logic [ADDR_W-1:0]         i_rd_addr,
    output logic                      o_rd_ready,
    input  logic                      i_wq_push,
    input  logic                      i_wq_full,
    input  logic                      i_wq_empty,
    input  logic [ADDR_W:0]           i_wq_head,
    input  logic [WIN*(ADDR_W+1)-1:0] i_wq_window,
    output logic                      o_wq_rd_en,
    output logic                      o_cmd_valid,
    output logic                      o_cmd_write,
    output logic [ADDR_W-1:0]         o_cmd_addr,
    input  logic                      i_cmd_ready,
    output logic [1:0]                o_mode,
    output logic [CW-1:0]             o_wcount,
    output logic                      o_hazard
);

    localparam int TW = $clog2(TURN_CYC + 1);
    localparam int BW = $clog2(WR_BURST_MAX + 1);

    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(WQ_DEPTH);
    localparam logic [CW-1:0] CNT_HI     = CW'(HI_WM);
    localparam logic [CW-1:0] CNT_LO     = CW'(LO_WM);
    localparam logic [CW-1:0] CNT_WIN    = CW'(WIN);
    localparam logic [TW-1:0] TURN_ZERO  = TW'(0);
    localparam logic [TW-1:0] TURN_ONE   = TW'(1);
    localparam logic [TW-1:0] TURN_LOAD  = TW'(TURN_CYC - 1);
    localparam logic [BW-1:0] BURST_ZERO = BW'(0);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(WR_BURST_MAX);

    sched_state_t      state_r;
    logic [CW-1:0]     wcount_r;
    logic [CW-1:0]     wcount_nxt_s;
    logic [TW-1:0]     turn_cnt_r;
    logic [BW-1:0]     burst_cnt_r;
    logic [BW-1:0]     burst_nxt_s;
    logic              active_r;
    logic              hit_s;
    logic              hazard_s;
    logic              cmd_valid_s;
    logic              cmd_write_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic              fire_s;
    logic              wr_fire_s;
    logic              hold_s;
    logic              wq_incoherent_s;
    logic              go_drain_s;
    logic              end_drain_s;

    raw_hazard_cmp #(
        .ADDR_W (ADDR_W),
        .WIN    (WIN)
    ) u_raw_hazard_cmp (
        .i_window (i_wq_window),
        .i_addr   (i_rd_addr),
        .o_hit    (hit_s)
    );

    // Entries older than the window are invisible, so a deep queue is treated as a hit
    always_comb begin
        hazard_s = active_r && i_rd_valid && (hit_s || (wcount_r > CNT_WIN));
    end

    // Command presented to the backend, derived from the registered mode
    always_comb begin
        cmd_valid_s = 1'b0;
        cmd_write_s = 1'b0;
        cmd_addr_s  = {ADDR_W{1'b0}};
        if (active_r) begin
            case (state_r)
                S_READ: begin
                    cmd_valid_s = i_rd_valid && !hazard_s;
                    cmd_write_s = 1'b0;
                    cmd_addr_s  = i_rd_addr;
                end
                S_WRITE: begin
                    cmd_valid_s = !i_wq_empty && i_wq_head[ADDR_W];
                    cmd_write_s = 1'b1;
                    cmd_addr_s  = i_wq_head[ADDR_W-1:0];
                end
                default: begin
                    cmd_valid_s = 1'b0;
                    cmd_write_s = 1'b0;
                    cmd_addr_s  = {ADDR_W{1'b0}};
                end
            endcase
        end else begin
            cmd_valid_s = 1'b0;
            cmd_write_s = 1'b0;
            cmd_addr_s  = {ADDR_W{1'b0}};
        end
    end

    // Handshake, occupancy and burst bookkeeping plus mode-change conditions
    always_comb begin
        fire_s          = cmd_valid_s && i_cmd_ready;
        wr_fire_s       = fire_s && cmd_write_s;
        hold_s          = cmd_valid_s && !i_cmd_ready;
        wq_incoherent_s = i_wq_empty && (wcount_r != CNT_ZERO);

        case ({i_wq_push, wr_fire_s})
            2'b10:   wcount_nxt_s = (wcount_r == CNT_MAX) ? wcount_r : wcount_r + CNT_ONE;
            2'b01:   wcount_nxt_s = (wcount_r == CNT_ZERO) ? wcount_r : wcount_r - CNT_ONE;
            default: wcount_nxt_s = wcount_r;
        endcase

        if (wr_fire_s && (burst_cnt_r != BURST_MAX)) begin
            burst_nxt_s = burst_cnt_r + BURST_ONE;
        end else begin
            burst_nxt_s = burst_cnt_r;
        end

        go_drain_s = (wcount_r >= CNT_HI) || i_wq_full
                   || (hazard_s && (wcount_r != CNT_ZERO))
                   || (!i_rd_valid && (wcount_r != CNT_ZERO));

        // Exit decisions use post-pop occupancy and post-fire burst length
        end_drain_s = !wq_incoherent_s
                   && ((wcount_nxt_s == CNT_ZERO)
                       || (i_rd_valid && !hazard_s && !i_wq_full
                           && ((wcount_nxt_s <= CNT_LO) || (burst_nxt_s >= BURST_MAX))));
    end

    // Mode FSM with occupancy, turnaround and burst counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= S_READ;
            wcount_r    <= CNT_ZERO;
            turn_cnt_r  <= TURN_ZERO;
            burst_cnt_r <= BURST_ZERO;
            active_r    <= 1'b0;
        end else begin
            active_r    <= 1'b1;
            wcount_r    <= wcount_nxt_s;
            burst_cnt_r <= burst_nxt_s;
            if (active_r && !hold_s) begin
                case (state_r)
                    S_READ: begin
                        if (go_drain_s) begin
                            state_r    <= S_R2W;
                            turn_cnt_r <= TURN_LOAD;
                        end
                    end
                    S_R2W: begin
                        if (turn_cnt_r == TURN_ZERO) begin
                            state_r     <= S_WRITE;
                            burst_cnt_r <= BURST_ZERO;
                        end else begin
                            turn_cnt_r <= turn_cnt_r - TURN_ONE;
                        end
                    end
                    S_WRITE: begin
                        if (end_drain_s) begin
                            state_r    <= S_W2R;
                            turn_cnt_r <= TURN_LOAD;
                        end
                    end
                    S_W2R: begin
                        if (turn_cnt_r == TURN_ZERO) begin
                            state_r <= S_READ;
                        end else begin
                            turn_cnt_r <= turn_cnt_r - TURN_ONE;
                        end
                    end
                    default: begin
                        state_r <= S_READ;
                    end
                endcase
            end
        end
    end

    assign o_cmd_valid = cmd_valid_s;
    assign o_cmd_write = cmd_write_s;
    assign o_cmd_addr  = cmd_addr_s;
    assign o_rd_ready  = fire_s && !cmd_write_s;
    assign o_wq_rd_en  = wr_fire_s;
    assign o_mode      = state_r;
    assign o_wcount    = wcount_r;
    assign o_hazard    = hazard_s;

endmodule

// File: tb/tb_write_drain_scheduler.sv
// Directed bench for write_drain_scheduler: a queue models the write FIFO and
// every expected value below is a hand-derived cycle-by-cycle constant.
module tb_write_drain_scheduler;
    import frontend_command_definition_pkg::*;

    localparam int AW    = DEF_ADDR_W;
    localparam int EW    = AW + 1;
    localparam int WIN   = WIN_SIZE;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_rd_valid;
    logic [AW-1:0]     i_rd_addr;
    logic              o_rd_ready;
    logic              i_wq_push;
    logic              i_wq_full;
    logic              i_wq_empty;
    logic [AW:0]       i_wq_head;
    logic [WIN*EW-1:0] i_wq_window;
    logic              o_wq_rd_en;
    logic              o_cmd_valid;
    logic              o_cmd_write;
    logic [AW-1:0]     o_cmd_addr;
    logic              i_cmd_ready;
    logic [1:0]        o_mode;
    logic [CW-1:0]     o_wcount;
    logic              o_hazard;

    int            tests_run;
    int            tests_failed;
    logic [AW-1:0] wq_q[$];
    logic [AW-1:0] push_addr;

    write_drain_scheduler dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rd_valid  (i_rd_valid),
        .i_rd_addr   (i_rd_addr),
        .o_rd_ready  (o_rd_ready),
        .i_wq_push   (i_wq_push),
        .i_wq_full   (i_wq_full),
        .i_wq_empty  (i_wq_empty),
        .i_wq_head   (i_wq_head),
        .i_wq_window (i_wq_window),
        .o_wq_rd_en  (o_wq_rd_en),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd_write (o_cmd_write),
        .o_cmd_addr  (o_cmd_addr),
        .i_cmd_ready (i_cmd_ready),
        .o_mode      (o_mode),
        .o_wcount    (o_wcount),
        .o_hazard    (o_hazard)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [1:0] mode, input logic valid,
                             input logic write, input logic [AW-1:0] addr);
        check_val({tag, "_mode"}, 32'(o_mode), 32'(mode));
        check_val({tag, "_valid"}, 32'(o_cmd_valid), 32'(valid));
        if (valid) begin
            check_val({tag, "_write"}, 32'(o_cmd_write), 32'(write));
            check_val({tag, "_addr"}, 32'(o_cmd_addr), 32'(addr));
        end
    endtask

    // Present the FIFO model on the head/window/flag inputs
    task automatic drive_wq();
        int n;
        int base;
        n           = wq_q.size();
        i_wq_empty  = (n == 0);
        i_wq_full   = (n == DEPTH);
        i_wq_head   = (n == 0) ? '0 : {1'b1, wq_q[0]};
        i_wq_window = '0;
        base        = (n > WIN) ? n - WIN : 0;
        for (int k = 0; k < WIN; k++) begin
            if (base + k < n) i_wq_window[k*EW +: EW] = {1'b1, wq_q[base+k]};
        end
    endtask

    // Advance one clock, applying the pop/push the DUT saw at that edge
    task automatic step();
        logic pop;
        pop = o_wq_rd_en;
        @(posedge i_clk);
        #1;
        if (pop && wq_q.size() > 0) wq_q.delete(0);
        if (i_wq_push && wq_q.size() < DEPTH) wq_q.push_back(push_addr);
        i_wq_push = 1'b0;
        drive_wq();
    endtask

    task automatic push(input logic [AW-1:0] a);
        i_wq_push = 1'b1;
        push_addr = a;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_rst_n      = 1'b0;
        i_rd_valid   = 1'b1;
        i_rd_addr    = AW'(32'h010);
        i_wq_push    = 1'b0;
        push_addr    = '0;
        i_cmd_ready  = 1'b1;
        wq_q.delete();
        drive_wq();
        #1;
        check_val("rst_valid", 32'(o_cmd_valid), 32'd0);
        check_val("rst_mode", 32'(o_mode), 32'(S_READ));
        check_val("rst_wcount", 32'(o_wcount), 32'd0);
        step();
        step();

        // Reset release: read issued on cycle 1
        i_rst_n = 1'b1;
        #1;
        check_val("t1_cycle0_valid", 32'(o_cmd_valid), 32'd0);
        step();
        #1;
        check_cmd("t1_read", S_READ, 1'b1, 1'b0, AW'(32'h010));
        check_val("t1_rd_ready", 32'(o_rd_ready), 32'd1);
        check_val("t1_wcount", 32'(o_wcount), 32'd0);
        step();

        // Watermark drain: 12 pushes under continuous reads
        i_rd_addr = AW'(32'h3FF);
        for (int c = 0; c < 12; c++) begin
            push(AW'(32'h100 + c));
            #1;
            check_val("t2_mode", 32'(o_mode), (c < 10) ? 32'(S_READ) : 32'(S_R2W));
            check_val("t2_wcount", 32'(o_wcount), 32'(c));
            check_val("t2_rd_ready", 32'(o_rd_ready), (c < 9) ? 32'd1 : 32'd0);
            if (c == 9) check_val("t2_deep_hazard", 32'(o_hazard), 32'd1);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            check_cmd("t2_write", S_WRITE, 1'b1, 1'b1, AW'(32'h100 + i));
            check_val("t2_pop", 32'(o_wq_rd_en), 32'd1);
            check_val("t2_drain_wcount", 32'(o_wcount), 32'(12 - i));
            step();
        end
        #1;
        check_cmd("t2_gap0", S_W2R, 1'b0, 1'b0, '0);
        check_val("t2_lo_wcount", 32'(o_wcount), 32'd4);
        step();
        #1;
        check_cmd("t2_gap1", S_W2R, 1'b0, 1'b0, '0);
        step();
        #1;
        check_cmd("t2_resume", S_READ, 1'b1, 1'b0, AW'(32'h3FF));
        check_val("t2_resume_ready", 32'(o_rd_ready), 32'd1);
        step();

        // Read-after-write hazard on 0x1A3
        push(AW'(32'h1A3));
        #1;
        check_val("t3_pre_ready", 32'(o_rd_ready), 32'd1);
        step();
        i_rd_addr = AW'(32'h1A3);
        #1;
        check_val("t3_hazard", 32'(o_hazard), 32'd1);
        check_val("t3_blocked", 32'(o_cmd_valid), 32'd0);
        check_val("t3_wcount", 32'(o_wcount), 32'd5);
        step();
        #1;
        check_cmd("t3_r2w0", S_R2W, 1'b0, 1'b0, '0);
        check_val("t3_hazard_r2w", 32'(o_hazard), 32'd1);
        step();
        #1;
        check_cmd("t3_r2w1", S_R2W, 1'b0, 1'b0, '0);
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check_cmd("t3_drain", S_WRITE, 1'b1, 1'b1, (i < 4) ? AW'(32'h108 + i) : AW'(32'h1A3));
            check_val("t3_hazard_drain", 32'(o_hazard), 32'd1);
            step();
        end
        #1;
        check_cmd("t3_w2r0", S_W2R, 1'b0, 1'b0, '0);
        check_val("t3_hazard_clear", 32'(o_hazard), 32'd0);
        step();
        step();
        #1;
        check_cmd("t3_read", S_READ, 1'b1, 1'b0, AW'(32'h1A3));
        check_val("t3_rd_ready", 32'(o_rd_ready), 32'd1);
        step();

        // Backpressure during a write, then simultaneous push and pop at wcount 6
        i_rd_valid = 1'b0;
        push(AW'(32'h200));
        #1;
        check_cmd("t4_idle", S_READ, 1'b0, 1'b0, '0);
        check_val("t4_wcount0", 32'(o_wcount), 32'd0);
        step();
        push(AW'(32'h201));
        #1;
        check_val("t4_wcount1", 32'(o_wcount), 32'd1);
        step();
        push(AW'(32'h202));
        #1;
        check_cmd("t4_r2w0", S_R2W, 1'b0, 1'b0, '0);
        step();
        push(AW'(32'h203));
        #1;
        check_cmd("t4_r2w1", S_R2W, 1'b0, 1'b0, '0);
        step();
        i_cmd_ready = 1'b0;
        for (int bp = 0; bp < 5; bp++) begin
            if (bp < 2) push(AW'(32'h204 + bp));
            #1;
            check_cmd("t4_stall", S_WRITE, 1'b1, 1'b1, AW'(32'h200));
            check_val("t4_no_pop", 32'(o_wq_rd_en), 32'd0);
            check_val("t4_stall_wcount", 32'(o_wcount), 32'(4 + ((bp < 2) ? bp : 2)));
            step();
        end
        i_cmd_ready = 1'b1;
        push(AW'(32'h206));
        #1;
        check_val("t4_pop", 32'(o_wq_rd_en), 32'd1);
        check_cmd("t4_fire", S_WRITE, 1'b1, 1'b1, AW'(32'h200));
        step();
        i_cmd_ready = 1'b0;
        push(AW'(32'h207));
        #1;
        check_val("t5_push_pop_wcount", 32'(o_wcount), 32'd6);
        check_cmd("t5_next_head", S_WRITE, 1'b1, 1'b1, AW'(32'h201));
        step();
        push(AW'(32'h208));
        step();
        push(AW'(32'h209));
        step();
        #1;
        check_val("t6_pre_wcount", 32'(o_wcount), 32'd9);
        check_val("t6_pre_mode", 32'(o_mode), 32'(S_WRITE));

        // Reset mid-drain
        i_rst_n = 1'b0;
        wq_q.delete();
        drive_wq();
        #1;
        check_cmd("t6_async", S_READ, 1'b0, 1'b0, '0);
        check_val("t6_async_wcount", 32'(o_wcount), 32'd0);
        step();
        #1;
        check_cmd("t6_edge", S_READ, 1'b0, 1'b0, '0);
        check_val("t6_edge_wcount", 32'(o_wcount), 32'd0);
        check_val("t6_edge_pop", 32'(o_wq_rd_en), 32'd0);
        check_val("t6_edge_addr", 32'(o_cmd_addr), 32'd0);
        step();

        // Fill to depth with the backend stalled, then a push while full saturates
        i_rst_n = 1'b1;
        for (int d = 0; d < 16; d++) begin
            push(AW'(32'h300 + d));
            #1;
            check_val("t5_fill_wcount", 32'(o_wcount), 32'(d));
            step();
        end
        #1;
        check_val("t5_full_wcount", 32'(o_wcount), 32'd16);
        check_cmd("t5_full_cmd", S_WRITE, 1'b1, 1'b1, AW'(32'h300));
        i_wq_push = 1'b1;
        step();
        #1;
        check_val("t5_sat_wcount", 32'(o_wcount), 32'd16);
        i_cmd_ready = 1'b1;
        #1;
        check_val("t5_sat_pop", 32'(o_wq_rd_en), 32'd1);
        step();
        #1;
        check_val("t5_after_pop_wcount", 32'(o_wcount), 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
